// File: rtl/pipelined_adder_if.sv
// ---------------------------------------------------------------------------
// pipelined_adder_if
//   Operand/result handshake bundle for pipelined_adder.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : the adder (drives in_ready and the registered result)
//   Signals:
//     in_valid/in_ready   operand beat handshake
//     a, b, c_in, sub     operands, carry-in, subtract select
//     out_valid/out_ready result beat handshake
//     sum, c_out, overflow result, carry out of MSB, signed overflow
// ---------------------------------------------------------------------------
interface pipelined_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             overflow;

   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
      input  in_ready, out_valid, sum, c_out, overflow
   );

   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
      output in_ready, out_valid, sum, c_out, overflow
   );
endinterface

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit adder/subtractor split into STAGES chunks of CHUNK bits; each
//   chunk is added in its own register stage, the carry crossing stages
//   through a register. Global-stall valid/ready flow control.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  pipelined_adder_if.slave (operands in, registered result out)
// ---------------------------------------------------------------------------
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input logic              clk,
   input logic              rst,
   pipelined_adder_if.slave bus
);
   localparam int CHUNK = WIDTH / STAGES;

   // Whole pipeline moves together unless the output beat is blocked.
   logic w_advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int LO = k * CHUNK;   // LSB of the chunk added here
      localparam int BW = WIDTH - LO;  // b_eff bits still to be added

      // r_s carries the computed low sum chunks and the untouched upper A
      // chunks in one word: chunk k is overwritten with its sum at stage k.
      logic [WIDTH-1:0] w_s_in;
      logic [BW-1:0]    w_b_in;
      logic             w_c_in;
      logic             w_vld_in;
      logic [CHUNK:0]   w_add;
      logic [WIDTH-1:0] w_s_nxt;
      logic             r_vld;
      logic             r_c;
      logic [WIDTH-1:0] r_s;

      if (k == 0) begin : g_head
         // Subtract is a + ~b + 1; c_in is ignored in that mode.
         assign w_s_in   = bus.a;
         assign w_b_in   = bus.sub ? ~bus.b : bus.b;
         assign w_c_in   = bus.sub | bus.c_in;
         assign w_vld_in = bus.in_valid;
      end else begin : g_body
         assign w_s_in   = g_stg[k-1].r_s;
         assign w_b_in   = g_stg[k-1].g_skew.r_b;
         assign w_c_in   = g_stg[k-1].r_c;
         assign w_vld_in = g_stg[k-1].r_vld;
      end

      assign w_add = {1'b0, w_s_in[LO +: CHUNK]} + {1'b0, w_b_in[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, w_c_in};

      always_comb begin
         w_s_nxt             = w_s_in;
         w_s_nxt[LO +: CHUNK] = w_add[CHUNK-1:0];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_vld <= 1'b0;
            r_c   <= 1'b0;
            r_s   <= '0;
         end else if (w_advance) begin
            r_vld <= w_vld_in;
            r_c   <= w_add[CHUNK];
            r_s   <= w_s_nxt;
         end
      end

      // B chunks not yet consumed travel down alongside, shrinking per stage.
      if (k < STAGES-1) begin : g_skew
         logic [BW-CHUNK-1:0] r_b;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)            r_b <= '0;
            else if (w_advance) r_b <= w_b_in[BW-1:CHUNK];
         end
      end

      // Carry into the MSB is a^b^sum at that bit; overflow is it XOR carry out.
      if (k == STAGES-1) begin : g_tail
         logic r_ovf;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               r_ovf <= 1'b0;
            else if (w_advance)
               r_ovf <= w_add[CHUNK]
                        ^ (w_s_in[WIDTH-1] ^ w_b_in[CHUNK-1] ^ w_add[CHUNK-1]);
         end
      end
   end

   assign w_advance     = !g_stg[STAGES-1].r_vld || bus.out_ready;
   assign bus.in_ready  = w_advance;
   assign bus.out_valid = g_stg[STAGES-1].r_vld;
   assign bus.sum       = g_stg[STAGES-1].r_s;
   assign bus.c_out     = g_stg[STAGES-1].r_c;
   assign bus.overflow  = g_stg[STAGES-1].g_tail.r_ovf;
endmodule

// File: tb/tb_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder
//   Directed checks on a WIDTH=16/STAGES=4 instance (carry chain, overflow,
//   subtract, backpressure, reset mid-flight), then random sweeps on
//   8/1, 32/8 and 12/3 instances against a full-width arithmetic model.
// ---------------------------------------------------------------------------
module tb_pipelined_adder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int vecs        = 0;
   int miscompares = 0;
   logic       sweep_go   = 1'b0;
   logic [2:0] sweep_done = 3'b000;

   pipelined_adder_if #(.WIDTH(16)) dbus ();
   pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (dbus)
   );

   // Reference: plain wide arithmetic, result packed as {ovf, c_out, sum64}.
   function automatic logic [65:0] model(input int w, input logic [63:0] a,
                                         input logic [63:0] b, input logic cin,
                                         input logic sub);
      logic [63:0] mask, am, be;
      logic [64:0] full;
      logic        ov;
      mask = (64'd1 << w) - 64'd1;
      am   = a & mask;
      be   = sub ? (~b & mask) : (b & mask);
      full = {1'b0, am} + {1'b0, be} + {64'd0, (sub | cin)};
      ov   = (am[w-1] == be[w-1]) && (full[w-1] != am[w-1]);
      return {ov, full[w], full[63:0] & mask};
   endfunction

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [65:0] dres();
      return {dbus.overflow, dbus.c_out, 48'd0, dbus.sum};
   endfunction

   // One isolated beat: checks acceptance, latency, result, single-cycle valid.
   task automatic send(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input logic [15:0] es,
                       input logic ec, input logic eo);
      int lat;
      @(negedge clk);
      dbus.a = a; dbus.b = b; dbus.c_in = cin; dbus.sub = sub;
      dbus.in_valid = 1'b1; dbus.out_ready = 1'b1;
      #1 chk({tag, "_rdy"}, 66'(dbus.in_ready), 66'(1));
      @(posedge clk); @(negedge clk);
      dbus.in_valid = 1'b0;
      lat = 0;
      while (!dbus.out_valid && lat < 12) begin
         @(posedge clk); @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, 66'(lat), 66'(3));
      chk({tag, "_res"}, dres(), {eo, ec, 48'd0, es});
      @(posedge clk); @(negedge clk);
      chk({tag, "_1cyc"}, 66'(dbus.out_valid), 66'(0));
   endtask

   logic [15:0] bp_a [10] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0F0F,
                              16'hA5A5, 16'h0001, 16'hC000, 16'h5555, 16'h0000};
   logic [15:0] bp_b [10] = '{16'h4321, 16'h0001, 16'h0001, 16'h8000, 16'hF0F0,
                              16'h5A5A, 16'hFFFF, 16'h4000, 16'hAAAA, 16'h0001};

   initial begin
      logic [65:0] q[$];
      logic [65:0] held, e;
      int sent, got, stale;
      held = '0;
      dbus.in_valid = 1'b0; dbus.a = '0; dbus.b = '0;
      dbus.c_in = 1'b0; dbus.sub = 1'b0; dbus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_vld",  66'(dbus.out_valid), 66'(0));
      chk("rst_res",  dres(), 66'(0));
      chk("rst_irdy", 66'(dbus.in_ready), 66'(1));

      send("carry",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      send("ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      send("cin",    16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
      send("sub_bw", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      send("sub_ov", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      send("sub_ok", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
      send("negov",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

      // Backpressure: 10 back-to-back beats, out_ready low for cycles 6..8.
      sent = 0; got = 0;
      for (int c = 0; c < 60 && got < 10; c++) begin
         @(negedge clk);
         dbus.out_ready = !(c >= 6 && c <= 8);
         dbus.in_valid  = (sent < 10);
         if (sent < 10) begin
            dbus.a = bp_a[sent]; dbus.b = bp_b[sent];
            dbus.c_in = sent[0]; dbus.sub = (sent % 3 == 0);
         end
         #1;
         if (!dbus.out_ready) begin
            chk("bp_irdy", 66'(dbus.in_ready), 66'(0));
            chk("bp_ovld", 66'(dbus.out_valid), 66'(1));
            if (c == 6) held = dres();
            else        chk("bp_hold", dres(), held);
         end
         if (dbus.out_valid && dbus.out_ready) begin
            if (q.size() == 0) chk("bp_extra", 66'(1), 66'(0));
            else begin
               e = q.pop_front();
               chk($sformatf("bp_res%0d", got), dres(), e);
            end
            got++;
         end
         if (dbus.in_valid && dbus.in_ready) begin
            q.push_back(model(16, 64'(dbus.a), 64'(dbus.b), dbus.c_in, dbus.sub));
            sent++;
         end
      end
      chk("bp_count", 66'(got), 66'(10));
      @(negedge clk);
      dbus.in_valid = 1'b0; dbus.out_ready = 1'b1;

      // Reset mid-flight: three beats accepted, then reset the next cycle.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         dbus.a = 16'h1111 * 16'(i + 1); dbus.b = 16'h0101;
         dbus.c_in = 1'b0; dbus.sub = 1'b0; dbus.in_valid = 1'b1;
      end
      @(negedge clk);
      dbus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mrst_vld", 66'(dbus.out_valid), 66'(0));
      chk("mrst_res", dres(), 66'(0));
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      stale = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (dbus.out_valid) stale++;
      end
      chk("mrst_stale", 66'(stale), 66'(0));
      send("post", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

      // Parameter sweep runs in the generate blocks below.
      sweep_go = 1'b1;
      for (int i = 0; i < 20000 && sweep_done != 3'b111; i++) @(posedge clk);
      chk("sweep_done", 66'(sweep_done), 66'(3'b111));

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

   for (genvar g = 0; g < 3; g++) begin : g_sw
      localparam int W = (g == 0) ? 8 : (g == 1) ? 32 : 12;
      localparam int S = (g == 0) ? 1 : (g == 1) ? 8  : 3;

      pipelined_adder_if #(.WIDTH(W)) sbus ();
      pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (sbus)
      );

      initial begin
         logic [65:0] q[$];
         logic [65:0] e;
         int n_in, n_out;
         sbus.in_valid = 1'b0; sbus.a = '0; sbus.b = '0;
         sbus.c_in = 1'b0; sbus.sub = 1'b0; sbus.out_ready = 1'b1;
         wait (sweep_go);
         n_in = 0; n_out = 0;
         for (int cyc = 0; cyc < 8000 && n_out < 1000; cyc++) begin
            @(negedge clk);
            sbus.in_valid  = (n_in < 1000) && ($urandom_range(3) != 0);
            sbus.a         = W'($urandom);
            sbus.b         = W'($urandom);
            sbus.c_in      = 1'($urandom);
            sbus.sub       = 1'($urandom);
            sbus.out_ready = ($urandom_range(3) != 0);
            #1;
            chk($sformatf("sw%0d_irdy", g), 66'(sbus.in_ready),
                66'(!sbus.out_valid || sbus.out_ready));
            if (sbus.out_valid && sbus.out_ready) begin
               if (q.size() == 0) chk($sformatf("sw%0d_extra", g), 66'(1), 66'(0));
               else begin
                  e = q.pop_front();
                  chk($sformatf("sw%0d_res%0d", g, n_out),
                      {sbus.overflow, sbus.c_out, 64'(sbus.sum)}, e);
               end
               n_out++;
            end
            if (sbus.in_valid && sbus.in_ready) begin
               q.push_back(model(W, 64'(sbus.a), 64'(sbus.b), sbus.c_in, sbus.sub));
               n_in++;
            end
         end
         chk($sformatf("sw%0d_count", g), 66'(n_out), 66'(1000));
         @(negedge clk);
         sbus.in_valid = 1'b0;
         sweep_done[g] = 1'b1;
      end
   end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

- Parametrised, pipelined ripple-carry adder/subtractor.
- Splits a WIDTH-bit operation into STAGES equal chunks; each chunk is added in its own register stage.
- Carry ripples between stages across clock edges.
- Valid/ready handshake on both sides; signed-overflow detection.
- Sits in the datapath wherever the team's combinational ripple adders miss timing at wide widths.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and chunk count; CHUNK = WIDTH/STAGES bits per stage; STAGES ≥ 1.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- c_in  input  1  carry in; ignored when sub=1.
- sub  input  1  0: a+b+c_in; 1: a−b (a + ~b + 1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- c_out  output  1  carry out of bit WIDTH−1; in sub mode 1 means no borrow (a ≥ b unsigned).
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Input transform at acceptance: b_eff = sub ? ~b : b; cin_eff = sub ? 1 : c_in.
- Stage k (0..STAGES−1) registers:
  - valid bit;
  - CHUNK-bit partial sum of chunk k (a[k], b_eff[k], carry from stage k−1's register; stage 0 uses cin_eff);
  - carry out;
  - not-yet-added upper operand chunks (skew);
  - already-computed lower sum chunks (deskew).
- Stage STAGES−1 additionally registers the carry into the MSB for overflow.
- Stage k only consumes values registered at stage k−1; no combinational carry path spans more than CHUNK bits.
- Flow control is a global stall:
  - advance = !out_valid || out_ready;
  - in_ready = advance (combinational from out_valid/out_ready);
  - all stage registers load only when advance=1.
- A beat transfers in when in_valid && in_ready.
- If in_valid=0 while advancing, a bubble (valid=0) enters stage 0; bubbles are not collapsed.
- Result transfers out when out_valid && out_ready.
- Results leave strictly in acceptance order; none dropped or duplicated.
- sum, c_out and overflow are register outputs. They hold their value while out_valid=1 && out_ready=0.

## Timing
- Reset (async assert, released synchronously to clk by the system): every valid bit = 0; sum = 0; c_out = 0; overflow = 0; out_valid = 0.
- in_ready = 1 from the first cycle after reset, since out_valid = 0.
- Latency: a beat accepted at edge N appears on out_valid/sum after edge N+STAGES−1 (STAGES register stages). No downstream stall is assumed.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: out_ready=0 with out_valid=1 freezes the whole pipeline the same cycle, forcing in_ready=0.
- Simultaneous output transfer and input acceptance in the same cycle is legal and lossless.
- Reset mid-operation: all in-flight beats are discarded; no partial result is ever presented.
- STAGES=1 degenerates to a single registered full-width adder with handshake, latency 1.
- Wrap-around: sum is modulo 2^WIDTH; the carry is reported only on c_out.

## Test plan
Default parameters (WIDTH=16, STAGES=4) unless noted.
- Carry across all chunks: a=0xFFFF, b=0x0001, c_in=0, sub=0 → 4 cycles after acceptance, sum=0x0000, c_out=1, overflow=0, out_valid=1 for exactly 1 cycle.
- Signed overflow: a=0x7FFF, b=0x0001, c_in=0 → sum=0x8000, c_out=0, overflow=1. Also a=0x1234, b=0x0FFF, c_in=1 → sum=0x2234, c_out=0, overflow=0.
- Subtract: sub=1, a=0x0005, b=0x0007, c_in=1 (ignored) → sum=0xFFFE, c_out=0, overflow=0. Also sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, c_out=1, overflow=1.
- Backpressure: stream 10 back-to-back random beats; hold out_ready=0 for 3 cycles mid-stream → in_ready=0 during those cycles, held outputs stable, all 10 results match a reference model in order, none lost.
- Reset mid-flight: accept 3 beats, assert rst on the next cycle → out_valid=0, sum=0, c_out=0, overflow=0 immediately. After release, no stale result ever appears; a new beat 0x0001+0x0001 yields 0x0002 at latency 4.
- Parameter sweep: WIDTH=8/STAGES=1, WIDTH=32/STAGES=8, WIDTH=12/STAGES=3 → 1000 random beats with random in_valid/out_ready, each checked exactly against a+b+c_in (or a−b) modulo 2^WIDTH, c_out and overflow.
